load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 209 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the CPU memory stage to a word-addressed request/grant/rvalid bus.
// One access is in flight at a time. The CPU is stalled from the cycle a
// request is presented until the completion pulse.
//
// Parameters
//   TIMEOUT     cycles allowed in REQ+WAIT before a bus fault (2..255)
//
// Ports
//   clk, rst    clock; synchronous active-low reset
//   req_*       CPU access: valid, write, funct3 size/sign code, byte
//               address, store data, load destination register
//   stall       freezes PC and register file (combinational)
//   resp_*      one-cycle completion: valid, reg-file write strobe,
//               extended load data, echoed destination register
//   fault       misaligned / illegal funct3 / timeout, qualified by resp_valid
//   mem_req/we/addr/be/wdata   bus request (word address, byte enables)
//   mem_gnt/rvalid/rdata       bus grant and response
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        resp_valid,
    output logic        resp_we,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Value of the busy counter during the last cycle allowed in REQ+WAIT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q;
    logic        fault_q;
    logic [31:0] rdata_q;

    logic        illegal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    // Legality of the access presented on the request port.
    // Stores only have B/H/W; loads add BU/HU. Size comes from funct3[1:0].
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        illegal = 1'b0;
        if (req_write) begin
            illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (req_funct3 inside {3'b011, 3'b110, 3'b111});
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            illegal = 1'b1;
        end
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            illegal = 1'b1;
        end
    end

    // Load lane extraction from the raw bus word, using the latched access.
    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'b0, ld_half};
            3'b010:  ld_data = mem_rdata;
            default: ld_data = '0;
        endcase
    end

    // Store lane placement: data is replicated so the byte enables alone
    // select the lane(s) the memory actually writes.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << addr_q[1:0];
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state    <= ST_IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rd_q     <= req_rd;
                        cnt_q    <= '0;
                        rdata_q  <= '0;
                        fault_q  <= illegal;
                        state    <= illegal ? ST_RESP : ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A grant on the final allowed cycle cannot be followed
                    // by a WAIT cycle, so the timeout wins here.
                    if (cnt_q == CNT_LAST) begin
                        fault_q <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (mem_gnt) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A response on the final allowed cycle still completes.
                    if (mem_rvalid) begin
                        rdata_q <= write_q ? '0 : ld_data;
                        state   <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        fault_q <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state and forced low while reset
    // is held, so nothing leaks out before the first reset edge.
    assign stall      = rst && ((state == ST_IDLE && req_valid) ||
                                state == ST_REQ || state == ST_WAIT);
    assign resp_valid = rst && (state == ST_RESP);
    assign fault      = resp_valid && fault_q;
    assign resp_we    = resp_valid && !write_q && !fault_q && (rd_q != 5'd0);
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_rd    = resp_valid ? rd_q : '0;

    assign mem_req    = rst && (state == ST_REQ);
    assign mem_we     = mem_req && write_q;
    assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : '0;
    assign mem_be     = mem_req ? st_be : '0;
    assign mem_wdata  = mem_req ? st_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Transaction-level reference: for each access the bench decides the grant and
// response delays, derives from them how many cycles must be spent requesting,
// waiting and whether a timeout occurs, and computes the bus lanes and load
// result arithmetically. A negedge compare process checks every cycle against
// those expectations. Two instances: default TIMEOUT and TIMEOUT=4.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    typedef struct packed {
        logic        stall;
        logic        resp_valid;
        logic        resp_we;
        logic [31:0] resp_rdata;
        logic [4:0]  resp_rd;
        logic        fault;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [3:0]  mem_be;
        logic [31:0] mem_wdata;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_m;
    logic        req_valid_t;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    outs_t m_o;
    outs_t t_o;
    outs_t a;
    outs_t e;
    bit    sel_t4 = 1'b0;
    bit    chk_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int          stall_cnt;
    int          mreq_cnt;
    int          resp_at;
    int          acc_at;
    logic [31:0] rec_addr;
    logic [31:0] rec_wdata;
    logic [3:0]  rec_be;
    logic [31:0] rec_rdata;
    logic        rec_we;
    logic        rec_fault;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_m), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .stall(m_o.stall), .resp_valid(m_o.resp_valid), .resp_we(m_o.resp_we),
        .resp_rdata(m_o.resp_rdata), .resp_rd(m_o.resp_rd), .fault(m_o.fault),
        .mem_req(m_o.mem_req), .mem_we(m_o.mem_we), .mem_addr(m_o.mem_addr),
        .mem_be(m_o.mem_be), .mem_wdata(m_o.mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_t), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .stall(t_o.stall), .resp_valid(t_o.resp_valid), .resp_we(t_o.resp_we),
        .resp_rdata(t_o.resp_rdata), .resp_rd(t_o.resp_rd), .fault(t_o.fault),
        .mem_req(t_o.mem_req), .mem_we(t_o.mem_we), .mem_addr(t_o.mem_addr),
        .mem_be(t_o.mem_be), .mem_wdata(t_o.mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    assign a = sel_t4 ? t_o : m_o;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_illegal(logic wr, logic [2:0] f3, logic [31:0] ad);
        bit ok_code;
        int size;
        if (wr) ok_code = (f3 <= 3'd2);
        else    ok_code = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size = 1 << f3[1:0];
        return !ok_code || ((int'(ad[1:0]) % size) != 0);
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] ad, logic [31:0] d);
        int v;
        if (f3[1:0] == 2'd0) begin
            v = int'((d >> (8 * int'(ad[1:0]))) & 32'hFF);
            if (!f3[2] && v >= 128) v = v - 256;
        end else if (f3[1:0] == 2'd1) begin
            v = int'((d >> (16 * int'(ad[1]))) & 32'hFFFF);
            if (!f3[2] && v >= 32768) v = v - 65536;
        end else begin
            v = int'(d);
        end
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] ad);
        if (f3[1:0] == 2'd0) return 4'(1 << int'(ad[1:0]));
        if (f3[1:0] == 2'd1) return 4'(3 << int'(ad[1:0]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] w);
        if (f3[1:0] == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(a.stall), 32'(e.stall));
            check("mem_req", 32'(a.mem_req), 32'(e.mem_req));
            check("resp_valid", 32'(a.resp_valid), 32'(e.resp_valid));
            if (e.mem_req) begin
                check("mem_we", 32'(a.mem_we), 32'(e.mem_we));
                check("mem_addr", a.mem_addr, e.mem_addr);
                check("mem_be", 32'(a.mem_be), 32'(e.mem_be));
                if (e.mem_we) check("mem_wdata", a.mem_wdata, e.mem_wdata);
            end
            if (e.resp_valid) begin
                check("fault", 32'(a.fault), 32'(e.fault));
                check("resp_we", 32'(a.resp_we), 32'(e.resp_we));
                check("resp_rdata", a.resp_rdata, e.resp_rdata);
                check("resp_rd", 32'(a.resp_rd), 32'(e.resp_rd));
            end
            if (a.stall) stall_cnt++;
            if (a.mem_req) begin
                if (mreq_cnt == 0) begin
                    rec_addr  = a.mem_addr;
                    rec_be    = a.mem_be;
                    rec_wdata = a.mem_wdata;
                end
                mreq_cnt++;
            end
            if (a.resp_valid) begin
                resp_at   = cyc;
                rec_rdata = a.resp_rdata;
                rec_we    = a.resp_we;
                rec_fault = a.fault;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input bit t4, input logic v);
        if (t4) req_valid_t = v;
        else    req_valid_m = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            e = '0;
            req_valid_m = 1'b0;
            req_valid_t = 1'b0;
            mem_gnt = 1'($urandom);
            mem_rvalid = 1'($urandom);
            mem_rdata = $urandom;
            step();
        end
    endtask

    task automatic run_txn(input bit t4, input logic wr, input logic [2:0] f3,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdat);
        int tmo, req_cyc, wait_cyc, n_req, n_wait;
        bit ill, tout, flt;
        tmo      = t4 ? 4 : 16;
        ill      = model_illegal(wr, f3, ad);
        req_cyc  = gnt_dly + 1;
        wait_cyc = rv_dly + 1;
        tout     = !ill && (req_cyc + wait_cyc > tmo);
        n_req    = ill ? 0 : ((req_cyc < tmo) ? req_cyc : tmo);
        n_wait   = ill ? 0 : (tout ? tmo - n_req : wait_cyc);
        flt      = ill || tout;

        sel_t4 = t4;
        stall_cnt = 0; mreq_cnt = 0; resp_at = -1;
        rec_addr = '0; rec_be = '0; rec_wdata = '0; rec_rdata = '0; rec_we = 0; rec_fault = 0;

        // acceptance cycle
        req_write = wr; req_funct3 = f3; req_addr = ad; req_wdata = wd; req_rd = rd;
        set_valid(t4, 1'b1);
        mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        e = '0; e.stall = 1'b1;
        acc_at = cyc;
        step();

        for (int k = 0; k < n_req; k++) begin
            mem_gnt = (k == gnt_dly);
            mem_rvalid = 1'($urandom);
            mem_rdata = $urandom;
            e = '0;
            e.stall = 1'b1; e.mem_req = 1'b1; e.mem_we = wr;
            e.mem_addr = ad & 32'hFFFF_FFFC;
            e.mem_be = model_be(f3, ad);
            e.mem_wdata = model_wdata(f3, wd);
            step();
        end
        for (int j = 0; j < n_wait; j++) begin
            mem_gnt = 1'($urandom);
            mem_rvalid = (j == rv_dly);
            mem_rdata = (j == rv_dly) ? rdat : $urandom;
            e = '0; e.stall = 1'b1;
            step();
        end

        // response cycle; requests presented now must be ignored
        set_valid(t4, 1'($urandom));
        mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        e = '0;
        e.resp_valid = 1'b1;
        e.fault = flt;
        e.resp_rd = rd;
        e.resp_we = !wr && !flt && (rd != 5'd0);
        e.resp_rdata = (wr || flt) ? 32'd0 : model_load(f3, ad, rdat);
        step();
        req_valid_m = 1'b0;
        req_valid_t = 1'b0;
        e = '0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] ad;
        logic        wr;
        int          gd, rv;

        rst = 1'b0;
        req_valid_m = 1'b1; req_valid_t = 1'b1;
        req_write = 1'b0; req_funct3 = 3'b010; req_addr = '0; req_wdata = '0; req_rd = 5'd1;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        // reset state: everything low even with a pending request
        check("reset_main_outputs_zero", 32'(m_o == '0), 32'd1);
        check("reset_t4_outputs_zero", 32'(t_o == '0), 32'd1);
        check("reset_stall", 32'(m_o.stall), 32'd0);
        rst = 1'b1;
        req_valid_m = 1'b0; req_valid_t = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        step();
        chk_en = 1'b1;
        idle(2);

        // LB at 0x103, top byte 0x80 -> sign-extended
        run_txn(0, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5, 0, 0, 32'h80FF_0000);
        check("lb_rdata", rec_rdata, 32'hFFFF_FF80);
        check("lb_we", 32'(rec_we), 32'd1);
        check("lb_min_latency", 32'(resp_at - acc_at), 32'd3);

        // LBU on the same access -> zero-extended
        run_txn(0, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd5, 0, 0, 32'h80FF_0000);
        check("lbu_rdata", rec_rdata, 32'h0000_0080);

        // SH at 0x202
        run_txn(0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd7, 1, 1, 32'h5555_5555);
        check("sh_mem_addr", rec_addr, 32'h0000_0200);
        check("sh_mem_be", 32'(rec_be), 32'b1100);
        check("sh_mem_wdata", rec_wdata, 32'hABCD_ABCD);
        check("sh_we", 32'(rec_we), 32'd0);

        // Misaligned LW at 0x6: fault on the cycle after acceptance, no bus request
        run_txn(0, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd3, 0, 0, 32'h1111_1111);
        check("lw_mis_fault", 32'(rec_fault), 32'd1);
        check("lw_mis_no_mem_req", 32'(mreq_cnt), 32'd0);
        check("lw_mis_latency", 32'(resp_at - acc_at), 32'd1);
        check("lw_mis_stall_cycles", 32'(stall_cnt), 32'd1);

        // Grant delayed 3, rvalid delayed 2
        run_txn(0, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd9, 3, 2, 32'hCAFE_F00D);
        check("delay_latency", 32'(resp_at - acc_at), 32'd8);
        check("delay_stall_cycles", 32'(stall_cnt), 32'd8);
        check("delay_rdata", rec_rdata, 32'hCAFE_F00D);

        // TIMEOUT=4 instance with no grant
        run_txn(1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd4, 1000, 0, 32'h0);
        check("tmo_fault", 32'(rec_fault), 32'd1);
        check("tmo_mem_req_cycles", 32'(mreq_cnt), 32'd4);
        check("tmo_latency", 32'(resp_at - acc_at), 32'd5);
        check("tmo_rdata", rec_rdata, 32'd0);
        sel_t4 = 1'b0;
        idle(1);

        // Reset while in WAIT, then a late rvalid
        chk_en = 1'b0;
        req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 5'd3;
        req_valid_m = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        step();
        mem_gnt = 1'b1;
        check("rst_seq_in_req", 32'(m_o.mem_req), 32'd1);
        step();
        mem_gnt = 1'b0;
        check("rst_seq_in_wait", 32'(m_o.stall && !m_o.mem_req && !m_o.resp_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_outputs_zero", 32'(m_o == '0), 32'd1);
        step();
        rst = 1'b1;
        req_valid_m = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rst_late_rvalid_quiet", 32'(m_o == '0), 32'd1);
            step();
            mem_rvalid = 1'b0;
        end
        chk_en = 1'b1;
        run_txn(0, 1'b0, 3'b001, 32'h0000_0302, 32'h0, 5'd8, 0, 0, 32'h8001_0002);
        check("post_rst_latency", 32'(resp_at - acc_at), 32'd3);
        check("post_rst_lh", rec_rdata, 32'hFFFF_8001);

        // Randomized accesses
        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                f3 = 3'($urandom);
            end else if (wr) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd2) ad[1:0] = 2'b00;
                else if (f3[1:0] == 2'd1) ad[0] = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                gd = $urandom_range(0, 12);
                rv = $urandom_range(0, 12);
            end else begin
                gd = $urandom_range(0, 3);
                rv = $urandom_range(0, 3);
            end
            run_txn((n % 10) == 9, wr, f3, ad, $urandom, 5'($urandom), gd, rv, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
